// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared types and helpers for the CNN pooling stage.
//   pool_state_t  : FSM encoding of the max-pool sequencer (IDLE/SCAN/DONE).
//   pool_out_size : floor output side for a given input side, window and step.
//   cnt_width     : counter width for a modulo-n counter (never below 1 bit).
//   relu          : clamps a two's-complement value of 'width' bits to >= 0.
//                   Only used when MAXPOOL_RELU_EN is defined.
// -----------------------------------------------------------------------------
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } pool_state_t;

  function automatic int pool_out_size(input int size_in, input int pool, input int stride);
    return (size_in - pool) / stride + 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Value is carried in the low 'width' bits; a set sign bit means negative.
  function automatic logic [63:0] relu(input logic [63:0] value, input int width);
    logic [63:0] sign_bit;
    sign_bit = (value >> (width - 1)) & 64'd1;
    if (sign_bit != 64'd0) begin
      return 64'd0;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/pool_window_max.sv
// -----------------------------------------------------------------------------
// pool_window_max
// Running maximum over one POOL x POOL window, one element per enabled cycle.
// Owns the in-window counters (kr rows, kc columns; kc fastest).
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset
//   first    in   new run accepted: zero counters and running max
//   enable   in   consume 'element' this cycle and advance kr/kc
//   element  in   [WIDTH-1:0] element currently addressed by the parent
//   max_next out  [WIDTH-1:0] max of window so far including 'element'
//   last     out  element at kr=kc=POOL-1 (window completes this cycle)
//   kr, kc   out  current in-window row/column offsets for addressing
// -----------------------------------------------------------------------------
module pool_window_max
  import cnn_pkg::*;
#(
  parameter int POOL  = 2,
  parameter int WIDTH = 8,
  localparam int KW   = cnt_width(POOL)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             first,
  input  logic             enable,
  input  logic [WIDTH-1:0] element,
  output logic [WIDTH-1:0] max_next,
  output logic             last,
  output logic [KW-1:0]    kr,
  output logic [KW-1:0]    kc
);

  localparam logic [KW-1:0] K_LAST = KW'(POOL - 1);

  logic [WIDTH-1:0] runmax;
  logic             win_first;

  // Window start seeds the max; afterwards strictly-greater replaces so ties keep the earlier value.
  always_comb begin
    win_first = (kr == {KW{1'b0}}) && (kc == {KW{1'b0}});
    last      = (kr == K_LAST) && (kc == K_LAST);
    if (win_first) begin
      max_next = element;
    end else if (element > runmax) begin
      max_next = element;
    end else begin
      max_next = runmax;
    end
  end

  // Running max register and in-window counters, kc wrapping into kr.
  always_ff @(posedge clock) begin
    if (reset || first) begin
      runmax <= {WIDTH{1'b0}};
      kr     <= {KW{1'b0}};
      kc     <= {KW{1'b0}};
    end else if (enable) begin
      runmax <= max_next;
      if (kc == K_LAST) begin
        kc <= {KW{1'b0}};
        if (kr == K_LAST) begin
          kr <= {KW{1'b0}};
        end else begin
          kr <= kr + KW'(1);
        end
      end else begin
        kc <= kc + KW'(1);
      end
    end else begin
      runmax <= runmax;
    end
  end

endmodule

// File: rtl/maxpool2d.sv
// -----------------------------------------------------------------------------
// maxpool2d
// Max-pooling stage behind conv2. On an accepted start the input matrix is
// snapshotted, then scanned one element per cycle window by window; each
// completed window writes one poolOut entry. A single done pulse closes a run.
// Optional build macro: MAXPOOL_RELU_EN -- elements are treated as signed and
// negatives are clamped to zero before comparison.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset (dominates everything)
//   start      in   begin pooling; only honoured in IDLE
//   inpMatrix  in   [WIDTH_BIT-1:0] [SIZE_IN][SIZE_IN], row-major
//   poolOut    out  [WIDTH_BIT-1:0] [SIZE_OUT][SIZE_OUT], registered
//   busy       out  high from the cycle after start until done (inclusive)
//   done       out  one-cycle pulse when poolOut is complete
// -----------------------------------------------------------------------------
module maxpool2d
  import cnn_pkg::*;
#(
  parameter int SIZE_IN   = 5,
  parameter int POOL      = 2,
  parameter int STRIDE    = 2,
  parameter int WIDTH_BIT = 8,
  localparam int SIZE_OUT = pool_out_size(SIZE_IN, POOL, STRIDE)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH_BIT-1:0] inpMatrix [SIZE_IN][SIZE_IN],
  output logic [WIDTH_BIT-1:0] poolOut   [SIZE_OUT][SIZE_OUT],
  output logic                 busy,
  output logic                 done
);

  localparam int OW = cnt_width(SIZE_OUT);
  localparam int KW = cnt_width(POOL);
  localparam int IW = cnt_width(SIZE_IN);
  localparam logic [OW-1:0] O_LAST = OW'(SIZE_OUT - 1);

  pool_state_t          state;
  logic [WIDTH_BIT-1:0] snap [SIZE_IN][SIZE_IN];
  logic [OW-1:0]        orow;
  logic [OW-1:0]        ocol;
  logic [KW-1:0]        kr;
  logic [KW-1:0]        kc;
  logic [IW-1:0]        row_idx;
  logic [IW-1:0]        col_idx;
  logic [WIDTH_BIT-1:0] raw_elem;
  logic [WIDTH_BIT-1:0] elem;
  logic [WIDTH_BIT-1:0] max_next;
  logic                 win_last;
  logic                 accept;
  logic                 scan_en;

  // Element addressing into the snapshot; the floor window grid never reaches past SIZE_IN-1.
  always_comb begin
    accept   = (state == IDLE) && start;
    scan_en  = (state == SCAN);
    row_idx  = IW'(int'(orow) * STRIDE + int'(kr));
    col_idx  = IW'(int'(ocol) * STRIDE + int'(kc));
    raw_elem = snap[row_idx][col_idx];
`ifdef MAXPOOL_RELU_EN
    elem     = WIDTH_BIT'(relu(64'(raw_elem), WIDTH_BIT));
`else
    elem     = raw_elem;
`endif
  end

  pool_window_max #(
    .POOL  (POOL),
    .WIDTH (WIDTH_BIT)
  ) u_window (
    .clock    (clock),
    .reset    (reset),
    .first    (accept),
    .enable   (scan_en),
    .element  (elem),
    .max_next (max_next),
    .last     (win_last),
    .kr       (kr),
    .kc       (kc)
  );

  // Sequencer: snapshot on start, window-by-window writeback, one-cycle DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      orow  <= {OW{1'b0}};
      ocol  <= {OW{1'b0}};
      for (int r = 0; r < SIZE_IN; r++) begin
        for (int c = 0; c < SIZE_IN; c++) begin
          snap[r][c] <= {WIDTH_BIT{1'b0}};
        end
      end
      for (int r = 0; r < SIZE_OUT; r++) begin
        for (int c = 0; c < SIZE_OUT; c++) begin
          poolOut[r][c] <= {WIDTH_BIT{1'b0}};
        end
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            snap  <= inpMatrix;
            orow  <= {OW{1'b0}};
            ocol  <= {OW{1'b0}};
            busy  <= 1'b1;
            state <= SCAN;
          end else begin
            busy  <= 1'b0;
          end
        end
        SCAN: begin
          if (win_last) begin
            poolOut[orow][ocol] <= max_next;
            if (ocol == O_LAST) begin
              ocol <= {OW{1'b0}};
              if (orow == O_LAST) begin
                orow  <= {OW{1'b0}};
                done  <= 1'b1;
                state <= DONE;
              end else begin
                orow  <= orow + OW'(1);
              end
            end else begin
              ocol <= ocol + OW'(1);
            end
          end else begin
            ocol <= ocol;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool2d.sv
// -----------------------------------------------------------------------------
// tb_maxpool2d
// Directed self-checking bench for maxpool2d at default parameters
// (5x5 in, 2x2 window, stride 2, 8-bit -> 2x2 out). Expected values are
// hand-computed; MAXPOOL_RELU_EN selects the clamped expectations.
// -----------------------------------------------------------------------------
module tb_maxpool2d;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] m  [5][5];
  logic [7:0] po [2][2];
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  int          lat;
  int          nbusy;
  int          ndone;
  logic [31:0] probe;

  maxpool2d dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .inpMatrix (m),
    .poolOut   (po),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // exp packs {[0][0], [0][1], [1][0], [1][1]}
  task automatic chk_pool(input string tag, input logic [31:0] exp);
    chk({tag, "_00"}, {24'd0, po[0][0]}, {24'd0, exp[31:24]});
    chk({tag, "_01"}, {24'd0, po[0][1]}, {24'd0, exp[23:16]});
    chk({tag, "_10"}, {24'd0, po[1][0]}, {24'd0, exp[15:8]});
    chk({tag, "_11"}, {24'd0, po[1][1]}, {24'd0, exp[7:0]});
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) m[r][c] = v;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) m[r][c] = 8'(5 * r + c);
  endtask

  task automatic fill_rev();
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) m[r][c] = 8'(24 - (5 * r + c));
  endtask

  // Start pulse at edge 0, then 17 further edges sampled #1 after each edge.
  // lat = index of the first post-start edge after which done is seen.
  task automatic run(input int restart_k, input int change_k, input int probe_k,
                     output int lat_o, output int nbusy_o, output int ndone_o,
                     output logic [31:0] probe_o);
    start = 1'b1;
    @(posedge clock); #1;
    start   = 1'b0;
    lat_o   = -1;
    nbusy_o = busy ? 1 : 0;
    ndone_o = done ? 1 : 0;
    probe_o = 32'd0;
    for (int k = 1; k <= 17; k++) begin
      if (k == restart_k) start = 1'b1;
      if (k == change_k) fill_const(8'h11);
      @(posedge clock); #1;
      start = 1'b0;
      if (busy) nbusy_o++;
      if (done) begin
        ndone_o++;
        if (lat_o < 0) lat_o = k;
      end
      if (k == probe_k) probe_o = {po[0][0], po[0][1], po[1][0], po[1][1]};
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fill_const(8'h00);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk_pool("rst_pool", 32'h00000000);

    // Ramp 5r+c: windows {0,1,5,6},{2,3,7,8},{10,11,15,16},{12,13,17,18}
    fill_ramp();
    run(-1, -1, -1, lat, nbusy, ndone, probe);
    chk("ramp_latency", lat, 32'd16);
    chk("ramp_busy_cycles", nbusy, 32'd17);
    chk("ramp_done_count", ndone, 32'd1);
    chk("ramp_idle_busy", {31'd0, busy}, 32'd0);
    chk_pool("ramp_pool", 32'h06081012);

    // All 0xFF
    fill_const(8'hFF);
    run(-1, -1, -1, lat, nbusy, ndone, probe);
    chk("ff_done_count", ndone, 32'd1);
`ifdef MAXPOOL_RELU_EN
    chk_pool("ff_pool", 32'h00000000);
`else
    chk_pool("ff_pool", 32'hFFFFFFFF);
`endif

    // Window (0,0) = {80,7F,01,00}, rest zero
    fill_const(8'h00);
    m[0][0] = 8'h80;
    m[0][1] = 8'h7F;
    m[1][0] = 8'h01;
    m[1][1] = 8'h00;
    run(-1, -1, -1, lat, nbusy, ndone, probe);
`ifdef MAXPOOL_RELU_EN
    chk_pool("sign_pool", 32'h7F000000);
`else
    chk_pool("sign_pool", 32'h80000000);
`endif

    // Start again at cycle 5 is ignored; matrix change at cycle 2 is invisible
    fill_ramp();
    run(5, 2, -1, lat, nbusy, ndone, probe);
    chk("restart_latency", lat, 32'd16);
    chk("restart_done_count", ndone, 32'd1);
    chk("restart_busy_cycles", nbusy, 32'd17);
    chk_pool("restart_pool", 32'h06081012);

    // Reset in the middle of a scan discards everything
    fill_const(8'h33);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (8) begin
      @(posedge clock); #1;
    end
    chk("partial_00", {24'd0, po[0][0]}, 32'h33);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk_pool("midrst_pool", 32'h00000000);
    @(posedge clock); #1;
    chk("midrst_stay_idle", {31'd0, busy}, 32'd0);

    fill_ramp();
    run(-1, -1, -1, lat, nbusy, ndone, probe);
    chk("fresh_latency", lat, 32'd16);
    chk("fresh_busy_cycles", nbusy, 32'd17);
    chk_pool("fresh_pool", 32'h06081012);

    // Back-to-back start in the IDLE cycle right after done, reversed ramp.
    // After 4 scan edges only window (0,0) has been rewritten.
    fill_rev();
    run(-1, -1, 4, lat, nbusy, ndone, probe);
    chk("b2b_probe", probe, 32'h18081012);
    chk("b2b_latency", lat, 32'd16);
    chk("b2b_done_count", ndone, 32'd1);
    chk_pool("b2b_pool", 32'h18160E0C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
